// File: rtl/aes_parameters.sv
// Shared AES definitions: round key bundle, FSM state type, S-box table,
// and the byte-level round helpers (SubBytes, ShiftRows, xtime, MixColumns).
// State bytes are FIPS-197 column-major: bits [127:120] hold byte 0.
package aes_parameters;

  localparam int unsigned AES_MAX_ROUNDS = 14;

  // Round keys in encryption order; entry 0 is the initial whitening key.
  typedef logic [AES_MAX_ROUNDS:0][127:0] round_keys_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_enc_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of the output takes column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_enc_round_logic.sv
// One combinational AES encryption round. MixColumns is skipped on the
// final round, selected by last_round.
module aes_enc_round_logic
  import aes_parameters::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [127:0] shifted;

  // SubBytes -> ShiftRows -> (MixColumns unless last) -> AddRoundKey
  always_comb begin
    shifted   = shift_rows(sub_bytes(state_in));
    state_out = (last_round ? shifted : mix_columns(shifted)) ^ round_key;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor: one round datapath reused once per cycle.
// Optional macro AES_ENC_OVERLAP_EN adds an output holding register so a
// new block can start while the previous result waits for aes_out_tready.
//
// Handshakes are AXI-stream style: a beat transfers on a rising clk edge
// where tvalid and tready are both 1; once raised, tvalid is held with
// stable tdata/tlast until that transfer happens.
module aes_encrypt_iter
  import aes_parameters::*;
#(
  parameter int unsigned MAX_ROUND_NUM = 14
)
(
  input  logic           clk,
  input  logic           resetn,
  input  round_keys_t    round_keys_i,
  input  logic           round_keys_valid_i,
  input  logic [127:0]   aes_in_tdata,
  input  logic           aes_in_tvalid,
  input  logic           aes_in_tlast,
  output logic           aes_in_tready,
  output logic [127:0]   aes_out_tdata,
  output logic           aes_out_tvalid,
  output logic           aes_out_tlast,
  input  logic           aes_out_tready,
  output aes_enc_state_e dbg_state
);

  localparam logic [3:0] LAST_CNT = 4'(MAX_ROUND_NUM);

  aes_enc_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   data_q, data_d;
  logic           last_q, last_d;
  logic [127:0]   round_out;
  logic           last_round;
  logic           in_fire;

  assign last_round    = (cnt_q == LAST_CNT);
  assign aes_in_tready = resetn && (state_q == IDLE) && round_keys_valid_i;
  assign in_fire       = aes_in_tvalid && aes_in_tready;
  assign dbg_state     = state_q;

  aes_enc_round_logic u_round (
    .state_in   (data_q),
    .round_key  (round_keys_i[cnt_q]),
    .last_round (last_round),
    .state_out  (round_out)
  );

`ifdef AES_ENC_OVERLAP_EN
  logic [127:0] hold_data_q, hold_data_d;
  logic         hold_last_q, hold_last_d;
  logic         hold_full_q, hold_full_d;
  logic         hold_free;

  // The holding register can take a result if empty or draining this cycle.
  assign hold_free      = !hold_full_q || aes_out_tready;
  assign aes_out_tvalid = hold_full_q;
  assign aes_out_tdata  = hold_data_q;
  assign aes_out_tlast  = hold_last_q;
`else
  assign aes_out_tvalid = (state_q == DONE);
  assign aes_out_tdata  = data_q;
  assign aes_out_tlast  = last_q;
`endif

  // Next-state and datapath update; losing round keys mid-block aborts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef AES_ENC_OVERLAP_EN
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q && !aes_out_tready;
`endif
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          data_d  = aes_in_tdata ^ round_keys_i[0];
          last_d  = aes_in_tlast;
          cnt_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (!round_keys_valid_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          data_d = round_out;
          cnt_d  = cnt_q + 4'd1;
          if (last_round) begin
`ifdef AES_ENC_OVERLAP_EN
            if (hold_free) begin
              hold_data_d = round_out;
              hold_last_d = last_q;
              hold_full_d = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
`ifdef AES_ENC_OVERLAP_EN
        if (hold_free) begin
          hold_data_d = data_q;
          hold_last_d = last_q;
          hold_full_d = 1'b1;
          state_d     = IDLE;
        end
`else
        if (aes_out_tready) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything visible on the outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef AES_ENC_OVERLAP_EN
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef AES_ENC_OVERLAP_EN
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: known-answer vectors, randomized blocks against
// a field-arithmetic AES model, backpressure, abort, mid-round reset, and a
// 10-round instance. Honours AES_ENC_OVERLAP_EN when compiled with it.
`timescale 1ns/1ps
module tb_aes_encrypt_iter;
  import aes_parameters::*;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  round_keys_t    rk14, rk10;
  logic           kv14, kv10;
  logic [127:0]   in14_data, out14_data, in10_data, out10_data;
  logic           in14_valid, in14_last, in14_ready, out14_valid, out14_last, out14_ready;
  logic           in10_valid, in10_last, in10_ready, out10_valid, out10_last, out10_ready;
  aes_enc_state_e dbg14, dbg10;

  aes_encrypt_iter #(.MAX_ROUND_NUM(14)) dut14 (
    .clk(clk), .resetn(resetn), .round_keys_i(rk14), .round_keys_valid_i(kv14),
    .aes_in_tdata(in14_data), .aes_in_tvalid(in14_valid), .aes_in_tlast(in14_last),
    .aes_in_tready(in14_ready), .aes_out_tdata(out14_data), .aes_out_tvalid(out14_valid),
    .aes_out_tlast(out14_last), .aes_out_tready(out14_ready), .dbg_state(dbg14)
  );

  aes_encrypt_iter #(.MAX_ROUND_NUM(10)) dut10 (
    .clk(clk), .resetn(resetn), .round_keys_i(rk10), .round_keys_valid_i(kv10),
    .aes_in_tdata(in10_data), .aes_in_tvalid(in10_valid), .aes_in_tlast(in10_last),
    .aes_in_tready(in10_ready), .aes_out_tdata(out10_data), .aes_out_tvalid(out10_valid),
    .aes_out_tlast(out10_last), .aes_out_tready(out10_ready), .dbg_state(dbg10)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  logic [7:0] m_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box = multiplicative inverse followed by the FIPS-197 affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
  endfunction

  // Key schedule; a 128-bit key sits in key[255:128].
  function automatic round_keys_t expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    round_keys_t rk;
    rk = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input round_keys_t rk, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   circ [4];
    logic [7:0]   acc;
    logic [127:0] res;
    circ[0] = 8'h02; circ[1] = 8'h03; circ[2] = 8'h01; circ[3] = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = m_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c + row] = s[4*((c + row) % 4) + row];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          if (r == nr) begin
            s[4*c + row] = t[4*c + row];
          end else begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(circ[(k - row + 4) % 4], t[4*c + k]);
            s[4*c + row] = acc;
          end
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- scoreboard ----------------
  logic [128:0] exp_q [$];
  logic [128:0] mon_e;
  logic         bp_random;

  // Every accepted output beat of dut14 must match the head of exp_q.
  always @(negedge clk) begin
    if (resetn && out14_valid && out14_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got %h expected no beat", out14_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_tdata", out14_data, mon_e[127:0]);
        check_bit("out_tlast", out14_last, mon_e[128]);
      end
    end
  end

  // Random output backpressure when enabled.
  always @(posedge clk) begin
    if (bp_random) begin
      #1;
      out14_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send14(input logic [127:0] d, input logic l);
    int n;
    @(posedge clk); #1;
    in14_data  = d;
    in14_last  = l;
    in14_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in14_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL in_handshake: got no tready after %0d cycles expected accept", n);
        in14_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in14_valid = 1'b0;
  endtask

  // Latency in clock edges counted from the handshake edge inclusive.
  task automatic wait_out14(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 100) begin
      @(negedge clk);
      if (out14_valid) begin
        lat = n + 1;
        return;
      end
      n++;
    end
  endtask

  task automatic wait_drain14();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && dbg14 == IDLE)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        return;
      end
    end
  endtask

  task automatic enc10(input logic [127:0] d, input logic [127:0] exp, input string name);
    int n;
    @(posedge clk); #1;
    in10_data  = d;
    in10_last  = 1'b1;
    in10_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in10_ready) break;
      n++;
      if (n > 100) break;
    end
    @(posedge clk); #1;
    in10_valid = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (out10_valid) break;
      n++;
    end
    check_int({name, "_latency"}, n + 1, 11);
    check({name, "_tdata"}, out10_data, exp);
    check_bit({name, "_tlast"}, out10_last, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         last;
  } vec_t;

  vec_t         vt [5];
  logic [255:0] cur_key;
  logic [255:0] rkey;
  logic [127:0] pt;
  logic         lb;
  int           lat;

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    kv14 = 1'b1; kv10 = 1'b1;
    in14_valid = 1'b0; in14_data = '0; in14_last = 1'b0; out14_ready = 1'b1;
    in10_valid = 1'b0; in10_data = '0; in10_last = 1'b0; out10_ready = 1'b1;
    bp_random = 1'b0;
    build_sbox();
    cur_key = C3_KEY;
    rk14 = expand_key(C3_KEY, 8, 14);
    rk10 = expand_key({C1_KEY, 128'h0}, 4, 10);

    vt[0] = '{C3_KEY, C3_PT, C3_CT, 1'b1};
    vt[1] = '{SP_KEY, 128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 1'b0};
    vt[2] = '{SP_KEY, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h591ccb10d410ed26dc5ba74a31362870, 1'b0};
    vt[3] = '{SP_KEY, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hb6ed21b99ca6f4f9f153e7b1beafed1d, 1'b0};
    vt[4] = '{SP_KEY, 128'hf69f2445df4f9b17ad2b417be66c3710, 128'h23304b7a39f9f3ff067d8d8f9e24ecc7, 1'b1};

    // Reset state, with keys valid so tready gating by reset is visible.
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("rst_in_tready", in14_ready, 1'b0);
    check_bit("rst_out_tvalid", out14_valid, 1'b0);
    check("rst_out_tdata", out14_data, 128'h0);
    check_bit("rst_out_tlast", out14_last, 1'b0);
    check_bit("rst_state_idle", dbg14 == IDLE, 1'b1);
    check_bit("rst_out10_tvalid", out10_valid, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_bit("post_rst_no_beat", out14_valid, 1'b0);
    end
    check_bit("post_rst_tready", in14_ready, 1'b1);

    // Known-answer table: C.3 with latency, then SP800-38A back-to-back.
    for (int i = 0; i < 5; i++) begin
      if (vt[i].key != cur_key) begin
        wait_drain14();
        cur_key = vt[i].key;
        rk14 = expand_key(cur_key, 8, 14);
      end
      exp_q.push_back({vt[i].last, vt[i].ct});
      send14(vt[i].pt, vt[i].last);
      if (i == 0) begin
        wait_out14(lat);
        check_int("c3_latency", lat, 15);
      end
    end
    wait_drain14();

    // Randomized blocks against the model, random key, random backpressure.
    for (int w = 0; w < 8; w++) rkey[32*w +: 32] = $urandom;
    cur_key = rkey;
    rk14 = expand_key(rkey, 8, 14);
    bp_random = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      lb = 1'($urandom_range(0, 1));
      exp_q.push_back({lb, model_enc(pt, rk14, 14)});
      send14(pt, lb);
    end
    wait_drain14();
    bp_random = 1'b0;
    repeat (2) @(posedge clk);
    #2 out14_ready = 1'b1;

    // Backpressure: result held stable for 20 cycles.
    cur_key = C3_KEY;
    rk14 = expand_key(C3_KEY, 8, 14);
    @(posedge clk); #1 out14_ready = 1'b0;
    exp_q.push_back({1'b1, C3_CT});
    send14(C3_PT, 1'b1);
    wait_out14(lat);
    check_int("bp_latency", lat, 15);
`ifdef AES_ENC_OVERLAP_EN
    pt = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back({1'b0, model_enc(pt, rk14, 14)});
    send14(pt, 1'b0);
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_bit("bp_tvalid_held", out14_valid, 1'b1);
      check("bp_tdata_held", out14_data, C3_CT);
      check_bit("bp_tlast_held", out14_last, 1'b1);
`ifndef AES_ENC_OVERLAP_EN
      check_bit("bp_in_tready", in14_ready, 1'b0);
`endif
    end
    @(posedge clk); #1 out14_ready = 1'b1;
    wait_drain14();

    // Abort: keys drop while round 7 is pending; nothing may come out.
    send14(C3_PT, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 kv14 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_bit("abort_state_idle", dbg14 == IDLE, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_bit("abort_no_tvalid", out14_valid, 1'b0);
      check_bit("abort_in_tready", in14_ready, 1'b0);
    end
    @(posedge clk); #1 kv14 = 1'b1;
    exp_q.push_back({1'b1, C3_CT});
    send14(C3_PT, 1'b1);
    wait_out14(lat);
    check_int("abort_recover_latency", lat, 15);
    wait_drain14();

    // Reset pulsed in round 5: outputs clear at once, then C.3 again.
    send14(C3_PT, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    check_bit("midrst_tvalid", out14_valid, 1'b0);
    check("midrst_tdata", out14_data, 128'h0);
    check_bit("midrst_tlast", out14_last, 1'b0);
    check_bit("midrst_in_tready", in14_ready, 1'b0);
    check_bit("midrst_state_idle", dbg14 == IDLE, 1'b1);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_bit("midrst_no_beat", out14_valid, 1'b0);
    end
    exp_q.push_back({1'b1, C3_CT});
    send14(C3_PT, 1'b1);
    wait_out14(lat);
    check_int("midrst_c3_latency", lat, 15);
    wait_drain14();

    // 10-round instance: FIPS-197 C.1 plus random blocks.
    enc10(C3_PT, C1_CT, "c1");
    for (int i = 0; i < 4; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      enc10(pt, model_enc(pt, rk10, 10), "aes128_rand");
    end

    check_int("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter MAX_ROUND_NUM, default 14, giving the number of rounds; legal values are 10, 12 and 14.
REQ-002 SHALL have the port clk  input  1  as the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port resetn  input  1  as the reset; asynchronous, active-low.
REQ-004 SHALL have the port round_keys_i  input  round_keys_t  carrying the encryption-order round keys [0..MAX_ROUND_NUM], 128 b each.
REQ-005 SHALL have the port round_keys_valid_i  input  1  which indicates that round_keys_i is stable and usable.
REQ-006 SHALL have the ports aes_in_tdata (input, 128, plaintext block), aes_in_tvalid (input, 1), aes_in_tlast (input, 1) and aes_in_tready (output, 1).
REQ-007 SHALL have the ports aes_out_tdata (output, 128, ciphertext block), aes_out_tvalid (output, 1), aes_out_tlast (output, 1) and aes_out_tready (input, 1).

Function
REQ-008 SHALL map the state bytes as FIPS-197 column-major; tdata[127:120] is byte 0.
REQ-009 SHALL implement an iterative core: one round datapath, reused once per cycle.
REQ-010 SHALL use the FSM states IDLE, ROUND and DONE.
REQ-011 SHALL drive aes_in_tready = 1 only in IDLE with round_keys_valid_i = 1.
REQ-012 SHALL, on an input handshake: load state <= tdata ^ round_keys_i[0], capture tlast, set round counter to 1, and go to ROUND.
REQ-013 SHALL, in each ROUND cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round_keys_i[cnt]), then cnt++.
REQ-014 SHALL omit MixColumns when cnt == MAX_ROUND_NUM; after that cycle the FSM goes to DONE.
REQ-015 SHALL give a fixed latency: handshake at edge T gives aes_out_tvalid = 1 after edge T+MAX_ROUND_NUM (15 cycles for 14 rounds).
REQ-016 SHALL, in DONE: hold aes_out_tvalid = 1 and keep tdata and tlast stable until aes_out_tready = 1, then return to IDLE. Without the macro this costs one bubble cycle per block.
REQ-017 SHALL treat round_keys_valid_i deasserting in ROUND as an abort: return to IDLE and emit no output.
REQ-018 SHALL keep a block in DONE when round_keys_valid_i deasserts; that result is still delivered.
REQ-019 SHALL keep aes_out_tvalid = 0 in all states other than DONE; aes_out_tdata is don't-care while aes_out_tvalid = 0.
REQ-020 SHALL ignore aes_in_tvalid when aes_in_tready = 0; no input is lost or duplicated.
REQ-021 SHALL pass aes_out_tlast through unchanged from the accepted input beat.

Reset
REQ-022 SHALL, on resetn low (any cycle, including mid-round): enter IDLE, and set cnt, state, aes_out_tvalid, aes_out_tlast and aes_out_tdata to 0.
REQ-023 SHALL hold aes_in_tready at 0 while resetn is low; reset removal does not cause any output beat.

Configuration
REQ-024 SHALL, with AES_ENC_OVERLAP_EN defined: add a 128+1 b output holding register, copy the result into it on completion, and return the FSM directly to IDLE. A new block may then be accepted while the previous result waits for aes_out_tready. If the holding register is still full at the end of the next block, the FSM stalls in DONE.
REQ-025 SHALL, without AES_ENC_OVERLAP_EN: have no holding register and behave exactly as REQ-016.

Structure
REQ-026 SHALL take round_keys_t, the S-box table/function, the xtime and MixColumns functions, and the ShiftRows function from the shared package aes_parameters; the module adds no local copies.
REQ-027 SHALL place the combinational round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) in the sub-module aes_enc_round_logic, which has a last_round input.

Verification
REQ-028 SHALL be checked with FIPS-197 C.3 (key 000102..1f, pt 00112233445566778899aabbccddeeff): output 8ea2b7ca516745bfeafc49904b496089 exactly 15 cycles after the handshake.
REQ-029 SHALL be checked with SP800-38A ECB-AES256 (key 603deb10..0914dff4), 4 back-to-back blocks with tlast on the 4th. Plaintexts 6bc1bee2..93172a, ae2d8a57..af8e51, 30c81c46..0a52ef, f69f2445..6c3710 give outputs f3eed1bd..b181f8, 591ccb10..362870, b6ed21b9..afed1d, 23304b7a..24ecc7 in order, with tlast only on the last.
REQ-030 SHALL be checked under backpressure: aes_out_tready held 0 for 20 cycles gives aes_out_tvalid and aes_out_tdata stable and aes_in_tready = 0 (macro off); with the macro on, the second block is accepted during the stall.
REQ-031 SHALL be checked with round_keys_valid_i dropped at round 7: no output beat, aes_in_tready = 0; once valid reasserts, the next block gives the correct ciphertext.
REQ-032 SHALL be checked with resetn pulsed low at round 5: all outputs 0 immediately, and after release the C.3 vector passes.
REQ-033 SHALL be checked with MAX_ROUND_NUM = 10 and the FIPS-197 C.1 vector (key 000102..0f): output 69c4e0d86a7b0430d8cdb78070b4c55a at 11-cycle latency.
